// File: rtl/reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reorder_buffer                                                           |
// | 15-entry circular ROB: tag allocation, CDB capture, in-order commit,     |
// | operand bypass and mispredict flush. Tag 0 means "no producer".          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reorder_buffer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            alloc_valid,
   input  logic            alloc_writes,
   input  logic [4:0]      alloc_dest,
   input  logic            alloc_is_store,
   output logic            alloc_ready,
   output logic [3:0]      alloc_tag,
   input  logic            cdb_valid,
   input  logic [3:0]      cdb_tag,
   input  logic [XLEN-1:0] cdb_value,
   input  logic            cdb_mispredict,
   input  logic [3:0]      src1_tag,
   input  logic [3:0]      src2_tag,
   output logic            src1_ready,
   output logic            src2_ready,
   output logic [XLEN-1:0] src1_value,
   output logic [XLEN-1:0] src2_value,
   input  logic            store_ack,
   output logic            commit_valid,
   output logic [3:0]      commit_tag,
   output logic [4:0]      commit_dest,
   output logic [XLEN-1:0] commit_value,
   output logic            commit_regwrite,
   output logic            commit_store,
   output logic            flush
);

   localparam int         NTAGS     = 15;
   localparam logic [3:0] FIRST_TAG = 4'd1;

   // Index 0 exists only so a raw 4-bit tag can address the arrays; it is never made valid.
   logic [15:0]     valid_q, valid_d;
   logic [15:0]     done_q, done_d;
   logic [15:0]     writes_q, writes_d;
   logic [15:0]     is_store_q, is_store_d;
   logic [15:0]     mispredict_q, mispredict_d;
   logic [4:0]      dest_q  [16];
   logic [4:0]      dest_d  [16];
   logic [XLEN-1:0] value_q [16];
   logic [XLEN-1:0] value_d [16];
   logic [3:0]      head_q, head_d;
   logic [3:0]      tail_q, tail_d;
   logic [3:0]      count_q, count_d;

   logic alloc_fire;

   function automatic logic [3:0] tag_inc(input logic [3:0] t);
      return (t == 4'd15) ? FIRST_TAG : t + 4'd1;
   endfunction

   always_comb begin
      commit_valid    = (count_q != 4'd0) && valid_q[head_q] && done_q[head_q] &&
                        (!is_store_q[head_q] || store_ack);
      flush           = commit_valid && mispredict_q[head_q];
      commit_tag      = commit_valid ? head_q : 4'd0;
      commit_dest     = commit_valid ? dest_q[head_q] : 5'd0;
      commit_value    = commit_valid ? value_q[head_q] : '0;
      commit_regwrite = commit_valid && writes_q[head_q] && (dest_q[head_q] != 5'd0);
      commit_store    = commit_valid && is_store_q[head_q];
      alloc_ready     = (count_q < 4'(NTAGS)) && !flush;
      alloc_tag       = tail_q;
      alloc_fire      = alloc_valid && alloc_ready;
   end

   // Same-cycle CDB broadcast takes precedence over the stored copy.
   always_comb begin
      src1_ready = 1'b0;
      src1_value = '0;
      src2_ready = 1'b0;
      src2_value = '0;
      if (src1_tag != 4'd0) begin
         if (cdb_valid && (cdb_tag == src1_tag)) begin
            src1_ready = 1'b1;
            src1_value = cdb_value;
         end else if (valid_q[src1_tag] && done_q[src1_tag]) begin
            src1_ready = 1'b1;
            src1_value = value_q[src1_tag];
         end
      end
      if (src2_tag != 4'd0) begin
         if (cdb_valid && (cdb_tag == src2_tag)) begin
            src2_ready = 1'b1;
            src2_value = cdb_value;
         end else if (valid_q[src2_tag] && done_q[src2_tag]) begin
            src2_ready = 1'b1;
            src2_value = value_q[src2_tag];
         end
      end
   end

   always_comb begin
      valid_d      = valid_q;
      done_d       = done_q;
      writes_d     = writes_q;
      is_store_d   = is_store_q;
      mispredict_d = mispredict_q;
      dest_d       = dest_q;
      value_d      = value_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;

      if (alloc_fire) begin
         valid_d[tail_q]      = 1'b1;
         done_d[tail_q]       = 1'b0;
         mispredict_d[tail_q] = 1'b0;
         writes_d[tail_q]     = alloc_writes;
         is_store_d[tail_q]   = alloc_is_store;
         dest_d[tail_q]       = alloc_dest;
         tail_d               = tag_inc(tail_q);
      end

      if (cdb_valid && (cdb_tag != 4'd0) && valid_q[cdb_tag]) begin
         done_d[cdb_tag]       = 1'b1;
         value_d[cdb_tag]      = cdb_value;
         mispredict_d[cdb_tag] = cdb_mispredict;
      end

      if (commit_valid) begin
         valid_d[head_q] = 1'b0;
         head_d          = tag_inc(head_q);
      end

      if (alloc_fire && !commit_valid) begin
         count_d = count_q + 4'd1;
      end else if (commit_valid && !alloc_fire) begin
         count_d = count_q - 4'd1;
      end

      // A mispredict commit discards every younger entry along with this cycle's alloc/CDB.
      if (flush) begin
         valid_d = '0;
         head_d  = FIRST_TAG;
         tail_d  = FIRST_TAG;
         count_d = 4'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         done_q       <= '0;
         writes_q     <= '0;
         is_store_q   <= '0;
         mispredict_q <= '0;
         for (int i = 0; i < 16; i++) begin
            dest_q[i]  <= '0;
            value_q[i] <= '0;
         end
         head_q  <= FIRST_TAG;
         tail_q  <= FIRST_TAG;
         count_q <= 4'd0;
      end else begin
         valid_q      <= valid_d;
         done_q       <= done_d;
         writes_q     <= writes_d;
         is_store_q   <= is_store_d;
         mispredict_q <= mispredict_d;
         dest_q       <= dest_d;
         value_q      <= value_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reorder_buffer                                                        |
// | Directed, self-checking bench for reorder_buffer.                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        alloc_valid, alloc_writes, alloc_is_store;
   logic [4:0]  alloc_dest;
   logic        alloc_ready;
   logic [3:0]  alloc_tag;
   logic        cdb_valid, cdb_mispredict;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic [3:0]  src1_tag, src2_tag;
   logic        src1_ready, src2_ready;
   logic [31:0] src1_value, src2_value;
   logic        store_ack;
   logic        commit_valid, commit_regwrite, commit_store, flush;
   logic [3:0]  commit_tag;
   logic [4:0]  commit_dest;
   logic [31:0] commit_value;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   reorder_buffer #(.XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .alloc_valid(alloc_valid), .alloc_writes(alloc_writes), .alloc_dest(alloc_dest),
      .alloc_is_store(alloc_is_store), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .cdb_mispredict(cdb_mispredict),
      .src1_tag(src1_tag), .src2_tag(src2_tag), .src1_ready(src1_ready), .src2_ready(src2_ready),
      .src1_value(src1_value), .src2_value(src2_value),
      .store_ack(store_ack),
      .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
      .commit_value(commit_value), .commit_regwrite(commit_regwrite),
      .commit_store(commit_store), .flush(flush)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 0; alloc_writes = 0; alloc_dest = 0; alloc_is_store = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_mispredict = 0;
      src1_tag = 0; src2_tag = 0; store_ack = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b want 1", alloc_ready); end
      vectors++; if (alloc_tag !== 4'd1) begin errors++; $display("FAIL reset_alloc_tag got %0d want 1", alloc_tag); end
      vectors++; if ({commit_valid, commit_tag, commit_dest, commit_value, commit_regwrite, commit_store} !== '0)
         begin errors++; $display("FAIL reset_commit got valid=%0b tag=%0d dest=%0d want all 0", commit_valid, commit_tag, commit_dest); end
      vectors++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", flush); end
   endtask

   task automatic test_alloc();
      for (int i = 1; i <= 3; i++) begin
         alloc_valid = 1; alloc_writes = 1; alloc_dest = 5'(4 + i);
         #1;
         vectors++; if (alloc_tag !== 4'(i)) begin errors++; $display("FAIL alloc_tag_%0d got %0d want %0d", i, alloc_tag, i); end
         tick();
      end
      idle();
      #1;
      vectors++; if (alloc_tag !== 4'd4) begin errors++; $display("FAIL alloc_tag_after3 got %0d want 4", alloc_tag); end
      vectors++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL alloc_no_commit got %0b want 0", commit_valid); end
   endtask

   task automatic test_in_order_commit();
      cdb_valid = 1; cdb_tag = 2; cdb_value = 32'hAA;
      tick();
      cdb_tag = 1; cdb_value = 32'h55;
      #1;
      vectors++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL order_hold got %0b want 0", commit_valid); end
      tick();
      idle();
      #1;
      vectors++; if ({commit_valid, commit_tag, commit_dest, commit_value, commit_regwrite} !== {1'b1, 4'd1, 5'd5, 32'h55, 1'b1})
         begin errors++; $display("FAIL commit_tag1 got v=%0b t=%0d d=%0d val=%0h rw=%0b want 1 1 5 55 1", commit_valid, commit_tag, commit_dest, commit_value, commit_regwrite); end
      tick();
      #1;
      vectors++; if ({commit_valid, commit_tag, commit_dest, commit_value} !== {1'b1, 4'd2, 5'd6, 32'hAA})
         begin errors++; $display("FAIL commit_tag2 got v=%0b t=%0d d=%0d val=%0h want 1 2 6 aa", commit_valid, commit_tag, commit_dest, commit_value); end
      tick();
      #1;
      vectors++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL commit_tag3_pending got %0b want 0", commit_valid); end
   endtask

   task automatic test_src_bypass();
      src1_tag = 3; src2_tag = 2;
      #1;
      vectors++; if (src1_ready !== 1'b0) begin errors++; $display("FAIL src1_not_ready got %0b want 0", src1_ready); end
      vectors++; if (src2_ready !== 1'b0) begin errors++; $display("FAIL src2_retired got %0b want 0", src2_ready); end
      cdb_valid = 1; cdb_tag = 3; cdb_value = 32'h1234; src2_tag = 0;
      #1;
      vectors++; if ({src1_ready, src1_value} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL src1_bypass got rdy=%0b val=%0h want 1 1234", src1_ready, src1_value); end
      vectors++; if ({src2_ready, src2_value} !== {1'b0, 32'h0}) begin errors++; $display("FAIL src2_tag0 got rdy=%0b val=%0h want 0 0", src2_ready, src2_value); end
      tick();
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
      #1;
      vectors++; if ({src1_ready, src1_value} !== {1'b1, 32'h1234}) begin errors++; $display("FAIL src1_stored got rdy=%0b val=%0h want 1 1234", src1_ready, src1_value); end
      vectors++; if ({commit_valid, commit_tag, commit_dest} !== {1'b1, 4'd3, 5'd7}) begin errors++; $display("FAIL commit_tag3 got v=%0b t=%0d d=%0d want 1 3 7", commit_valid, commit_tag, commit_dest); end
      tick();
      idle();
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         alloc_valid = 1; alloc_writes = 1; alloc_dest = 5'(i);
         #1;
         vectors++; if ({alloc_ready, alloc_tag} !== {1'b1, 4'(i)}) begin errors++; $display("FAIL fill_%0d got rdy=%0b tag=%0d want 1 %0d", i, alloc_ready, alloc_tag, i); end
         tick();
      end
      alloc_dest = 5'd30;
      #1;
      vectors++; if ({alloc_ready, alloc_tag} !== {1'b0, 4'd1}) begin errors++; $display("FAIL full got rdy=%0b tag=%0d want 0 1", alloc_ready, alloc_tag); end
      tick();
      idle();
      cdb_valid = 1; cdb_tag = 1; cdb_value = 32'h100;
      tick();
      idle();
      #1;
      vectors++; if ({commit_valid, commit_tag, commit_dest, alloc_ready} !== {1'b1, 4'd1, 5'd1, 1'b0})
         begin errors++; $display("FAIL full_commit got v=%0b t=%0d d=%0d rdy=%0b want 1 1 1 0", commit_valid, commit_tag, commit_dest, alloc_ready); end
      tick();
      #1;
      vectors++; if ({alloc_ready, alloc_tag} !== {1'b1, 4'd1}) begin errors++; $display("FAIL after_commit got rdy=%0b tag=%0d want 1 1", alloc_ready, alloc_tag); end
      alloc_valid = 1; alloc_writes = 1; alloc_dest = 5'd20;
      tick();
      idle();
      #1;
      vectors++; if ({alloc_ready, alloc_tag, commit_valid} !== {1'b0, 4'd2, 1'b0}) begin errors++; $display("FAIL refill got rdy=%0b tag=%0d cv=%0b want 0 2 0", alloc_ready, alloc_tag, commit_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         alloc_valid = 1; alloc_writes = (i != 4); alloc_dest = 5'(i);
         tick();
      end
      idle();
      for (int i = 1; i <= 4; i++) begin
         cdb_valid = 1; cdb_tag = 4'(i); cdb_value = 32'(16 * i); cdb_mispredict = (i == 4);
         #1;
         if (i > 1) begin
            vectors++; if ({commit_valid, commit_tag, flush} !== {1'b1, 4'(i - 1), 1'b0}) begin errors++; $display("FAIL flush_pre_%0d got v=%0b t=%0d f=%0b want 1 %0d 0", i, commit_valid, commit_tag, flush, i - 1); end
         end
         tick();
      end
      cdb_valid = 1; cdb_tag = 5; cdb_value = 32'h5; cdb_mispredict = 0;
      alloc_valid = 1; alloc_writes = 1; alloc_dest = 5'd9;
      #1;
      vectors++; if ({flush, commit_valid, commit_tag, commit_regwrite, alloc_ready} !== {1'b1, 1'b1, 4'd4, 1'b0, 1'b0})
         begin errors++; $display("FAIL flush_cycle got f=%0b v=%0b t=%0d rw=%0b rdy=%0b want 1 1 4 0 0", flush, commit_valid, commit_tag, commit_regwrite, alloc_ready); end
      tick();
      idle();
      src1_tag = 5;
      #1;
      vectors++; if ({flush, commit_valid, alloc_ready, alloc_tag} !== {1'b0, 1'b0, 1'b1, 4'd1})
         begin errors++; $display("FAIL post_flush got f=%0b v=%0b rdy=%0b tag=%0d want 0 0 1 1", flush, commit_valid, alloc_ready, alloc_tag); end
      vectors++; if (src1_ready !== 1'b0) begin errors++; $display("FAIL post_flush_src got %0b want 0", src1_ready); end
      idle();
   endtask

   task automatic test_store_stall();
      alloc_valid = 1; alloc_is_store = 1; alloc_writes = 0; alloc_dest = 0;
      tick();
      alloc_is_store = 0; alloc_writes = 1; alloc_dest = 0;
      cdb_valid = 1; cdb_tag = 1; cdb_value = 32'h0;
      tick();
      idle();
      cdb_valid = 1; cdb_tag = 2; cdb_value = 32'h7;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++; if ({commit_valid, commit_store} !== 2'b00) begin errors++; $display("FAIL store_stall_%0d got v=%0b st=%0b want 0 0", c, commit_valid, commit_store); end
         tick();
         idle();
      end
      store_ack = 1;
      #1;
      vectors++; if ({commit_valid, commit_tag, commit_store, commit_regwrite} !== {1'b1, 4'd1, 1'b1, 1'b0})
         begin errors++; $display("FAIL store_commit got v=%0b t=%0d st=%0b rw=%0b want 1 1 1 0", commit_valid, commit_tag, commit_store, commit_regwrite); end
      tick();
      store_ack = 0;
      #1;
      vectors++; if ({commit_valid, commit_tag, commit_store, commit_regwrite, commit_value} !== {1'b1, 4'd2, 1'b0, 1'b0, 32'h7})
         begin errors++; $display("FAIL dest0_commit got v=%0b t=%0d st=%0b rw=%0b val=%0h want 1 2 0 0 7", commit_valid, commit_tag, commit_store, commit_regwrite, commit_value); end
      tick();
   endtask

   task automatic test_reset_priority();
      alloc_valid = 1; alloc_is_store = 1;
      tick();
      idle();
      cdb_valid = 1; cdb_tag = 3; cdb_value = 32'h9;
      tick();
      idle();
      store_ack = 1; reset = 1;
      tick();
      reset = 0; idle();
      #1;
      vectors++; if ({commit_valid, alloc_tag, alloc_ready} !== {1'b0, 4'd1, 1'b1}) begin errors++; $display("FAIL reset_prio got v=%0b tag=%0d rdy=%0b want 0 1 1", commit_valid, alloc_tag, alloc_ready); end
   endtask

   initial begin
      reset = 1;
      idle();
      test_reset();
      test_alloc();
      test_in_order_commit();
      test_src_bypass();
      test_full_wrap();
      test_flush();
      test_store_stall();
      test_reset_priority();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
